// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - sampled edge-event detector with round-robin single-consumer handout
module edge_event_arbiter #(
  parameter int                CHANNELS = 4,
  parameter int                BITS     = 3,
  parameter logic [BITS-1:0]   TRIGGER  = 3'b011,
  parameter int                TICK_DIV = 4,
  localparam int               CW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                i_sclr_n,
  input  logic                i_en,
  input  logic [CHANNELS-1:0] i_dat,
  input  logic                i_ready,
  input  logic                i_clr_ovf,
  output logic                o_valid,
  output logic [CW-1:0]       o_chan,
  output logic [CHANNELS-1:0] o_overflow
);

  localparam int              CNTW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CH_LAST  = CW'(CHANNELS - 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNTW-1:0]     r_cnt;
  logic                w_tick;
  logic [BITS-1:0]     r_hist     [CHANNELS];
  logic [BITS-1:0]     w_hist_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_evt;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] r_ovf;
  logic [CW-1:0]       r_rr, w_rr_nxt;
  logic [CW-1:0]       r_chan, w_chan_nxt;
  logic [CW-1:0]       w_sel;
  logic                w_any;
  logic                r_valid, w_valid_nxt;

  assign w_tick = i_en && (r_cnt == CNT_LAST);

  // Sample-tick divider; frozen while disabled.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  // Candidate history per channel and pattern match against it.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_hist_nxt[k] = {r_hist[k][BITS-2:0], i_dat[k]};
      w_evt[k]      = w_tick && (w_hist_nxt[k] == TRIGGER);
    end
  end

  // Shift the new sample into every history on a tick.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      for (int k = 0; k < CHANNELS; k++) r_hist[k] <= '0;
    end else if (w_tick) begin
      for (int k = 0; k < CHANNELS; k++) r_hist[k] <= w_hist_nxt[k];
    end
  end

  // First pending channel at or after the round-robin pointer; iterate from the
  // far end so the closest hit is the last one written.
  always_comb begin
    logic [CW-1:0] idx;
    idx   = '0;
    w_any = 1'b0;
    w_sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = CW'((int'(r_rr) + i) % CHANNELS);
      if (r_pend[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  assign w_clr = (r_state == S_IDLE && w_any) ? (CHANNELS'(1) << w_sel) : '0;

  // Pending set beats a same-cycle grant clear so a fresh event is never lost.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_evt;
    end
  end

  // Sticky lost-event flags; a new overflow outranks the clear strobe.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (i_clr_ovf ? '0 : r_ovf) | (w_evt & r_pend & ~w_clr);
    end
  end

  // Grant FSM next-state: IDLE picks a channel, OFFER holds it until accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_chan_nxt  = r_chan;
    w_rr_nxt    = r_rr;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt = S_OFFER;
          w_valid_nxt = 1'b1;
          w_chan_nxt  = w_sel;
        end
      end
      S_OFFER: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_rr_nxt    = (r_chan == CH_LAST) ? '0 : r_chan + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Grant FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_chan  <= w_chan_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  assign o_valid    = r_valid;
  assign o_chan     = r_chan;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed bench for edge_event_arbiter
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       i_sclr_n;
  logic       i_en;
  logic [3:0] i_dat;
  logic       i_ready;
  logic       i_clr_ovf;
  logic       o_valid;
  logic [1:0] o_chan;
  logic [3:0] o_overflow;

  int total = 0;
  int bad   = 0;
  int tb_cnt = 0;
  bit last_tick = 1'b0;

  always #5 clk = ~clk;

  edge_event_arbiter dut (
    .clk        (clk),
    .i_sclr_n   (i_sclr_n),
    .i_en       (i_en),
    .i_dat      (i_dat),
    .i_ready    (i_ready),
    .i_clr_ovf  (i_clr_ovf),
    .o_valid    (o_valid),
    .o_chan     (o_chan),
    .o_overflow (o_overflow)
  );

  // one clock edge; tracks the expected sample-tick position (TICK_DIV=4)
  task automatic step();
    last_tick = i_sclr_n && i_en && (tb_cnt == 3);
    if (!i_sclr_n) tb_cnt = 0;
    else if (i_en) tb_cnt = (tb_cnt == 3) ? 0 : tb_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_tick && n < 8);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(o_valid), 32'd0);
  endtask

  task automatic chk_offer(input string tag, input int ch);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".chan"}, 32'(o_chan), 32'(ch));
  endtask

  initial begin
    i_sclr_n  = 1'b0;
    i_en      = 1'b1;
    i_ready   = 1'b1;
    i_clr_ovf = 1'b0;
    i_dat     = 4'h0;

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      i_dat = 4'($urandom);
      step();
      chk_idle("rst");
      chk("rst.chan", 32'(o_chan), 32'd0);
      chk("rst.ovf", 32'(o_overflow), 32'd0);
    end

    // three quiet ticks after release
    i_sclr_n = 1'b1;
    i_dat    = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_idle("quiet");
    end

    // round robin: ch0, ch1, ch3 together; ch0 re-triggers while ch1 is held
    i_dat = 4'b1011;
    next_tick(); chk_idle("rr.t1");
    next_tick(); chk_idle("rr.t2");
    i_dat = 4'b1010;
    step(); chk_offer("rr.g0", 0);
    step(); chk_idle("rr.b0");
    step(); chk_offer("rr.g1", 1);
    i_ready = 1'b0;
    next_tick(); chk_offer("rr.hold1", 1);
    i_dat = 4'b1011;
    next_tick(); chk_offer("rr.hold2", 1);
    next_tick(); chk_offer("rr.hold3", 1);
    i_ready = 1'b1;
    step(); chk_idle("rr.b1");
    step(); chk_offer("rr.g3", 3);
    step(); chk_idle("rr.b3");
    step(); chk_offer("rr.g0b", 0);
    step(); chk_idle("rr.b0b");

    // single rising edge on ch2
    i_dat = 4'b1111;
    next_tick(); chk_idle("se.t1");
    next_tick(); chk_idle("se.t2");
    step(); chk_offer("se.g2", 2);
    step(); chk_idle("se.drop");
    step(); chk_idle("se.after");

    // backpressure and overflow on ch1
    i_ready = 1'b0;
    i_dat = 4'b1101; next_tick();
    i_dat = 4'b1111; next_tick();
    next_tick(); chk_idle("ov.e1");
    chk("ov.none0", 32'(o_overflow), 32'd0);
    step(); chk_offer("ov.g1", 1);
    i_dat = 4'b1101; next_tick();
    i_dat = 4'b1111; next_tick();
    next_tick(); chk_offer("ov.e2", 1);
    chk("ov.none1", 32'(o_overflow), 32'd0);
    i_dat = 4'b1101; next_tick();
    i_dat = 4'b1111; next_tick();
    next_tick(); chk_offer("ov.e3", 1);
    chk("ov.set", 32'(o_overflow), 32'b0010);
    i_clr_ovf = 1'b1;
    step(); chk("ov.clr", 32'(o_overflow), 32'd0);
    i_clr_ovf = 1'b0;
    i_ready = 1'b1;
    step(); chk_idle("ov.b");
    step(); chk_offer("ov.pend", 1);
    step(); chk_idle("ov.done");

    // enable gating with an offer in flight
    i_ready = 1'b0;
    i_dat = 4'b1110; next_tick();
    i_dat = 4'b1111; next_tick();
    next_tick(); chk_idle("en.e");
    step(); chk_offer("en.g0", 0);
    i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_dat   = (i % 2 == 1) ? 4'b1111 : 4'b0000;
      i_ready = (i >= 10);
      step();
      chk({"en.gate", (i < 10) ? ".held" : ".done"}, 32'(o_valid), (i < 10) ? 32'd1 : 32'd0);
      if (i < 10) chk("en.gate.chan", 32'(o_chan), 32'd0);
    end
    i_en = 1'b1;
    next_tick(); chk_idle("en.frozen1");
    step(); chk_idle("en.frozen2");

    // mid-offer reset with ch3 still pending behind ch2
    i_dat = 4'b0011; next_tick();
    i_dat = 4'b1111; next_tick();
    next_tick(); chk_idle("mr.e");
    i_ready = 1'b0;
    step(); chk_offer("mr.g2", 2);
    i_sclr_n = 1'b0;
    step();
    chk_idle("mr.rst");
    chk("mr.chan", 32'(o_chan), 32'd0);
    chk("mr.ovf", 32'(o_overflow), 32'd0);
    i_sclr_n = 1'b1;
    i_dat    = 4'b0011;
    i_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_idle("mr.nopend");
    end
    step(); chk_offer("mr.rr0", 0);
    step(); chk_idle("mr.b0");
    step(); chk_offer("mr.rr1", 1);
    step(); chk_idle("mr.b1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
